jtcps1_gfx_bank_lut: RTL and testbench
======================================

// Module: jtcps1_gfx_bank_lut
// PURPOSE
//  Pipelined, runtime-configurable GFX code-to-bank mapper; parametrised successor to the static range matcher.
//  Takes a tile/sprite code plus gfx type from a layer fetcher, finds the first enabled range entry that matches,
//  and returns a rebased ROM code with a bank index. Sits between the layer engines and the SDRAM GFX port.
//  The range table is written byte-wise by the game-config loader at boot and may be rewritten at run time.
// PARAMETERS
//  NENTRY  8   number of range entries (1..16)
//  CODEW  10   width of code_in/code_out (ROM address bits [19:10] by default)
//  TYPEW   5   gfx type one-hot width (OBJ, SCR1, SCR2, SCR3, STAR)
//  NBANK   4   number of ROM banks; BANKW=$clog2(NBANK)
// PORTS
//  clk        in   1             system clock
//  rst        in   1             async reset, active-high
//  cfg_we     in   1             table byte write strobe
//  cfg_addr   in   $clog2(NENTRY*EB)  byte address: entry=addr/EB, lane=addr%EB
//  cfg_din    in   8             table write data
//  bank_base  in   NBANK*CODEW   per-bank base code, static during lookups
//  in_valid   in   1             lookup request
//  in_ready   out  1             request accepted when in_valid&in_ready
//  gfx_type   in   TYPEW         one-hot type of the request
//  code_in    in   CODEW         raw code
//  out_valid  out  1             result valid
//  out_ready  in   1             consumer accepts result
//  code_out   out  CODEW         rebased code
//  bank       out  BANKW         matched bank index
//  miss       out  1             no entry matched
// BEHAVIOUR
//  - Entry layout LSB first: start[CODEW], end[CODEW], tmask[TYPEW], bank[BANKW], en[1]; ENTRYW bits,
//    EB=ceil(ENTRYW/8) bytes; unused high bits of last byte ignored. cfg_addr>=NENTRY*EB: write dropped.
//  - Reset: all entries cleared (en=0), out_valid=0, code_out=0, bank=0, miss=0. in_ready=1 one cycle after reset release.
//  - Match(i): en && start<=code_in<=end (unsigned, inclusive) && |(tmask & gfx_type). start>end never matches.
//  - Priority: lowest matching index wins.
//  - Stage 1 (at acceptance): evaluate all matches, priority-encode, register code_in, winning start and bank, miss.
//  - Stage 2: code_out = bank_base[bank] + (code_in - start), modulo 2^CODEW (wrap, no saturation).
//  - Miss: code_out=code_in, bank=0, miss=1.
//  - Latency: 2 cycles from accept to out_valid when out_ready stays high; throughput 1/cycle.
//  - Backpressure: adv = !out_valid | out_ready; both stages advance only on adv; in_ready = adv (combinational).
//    Outputs hold stable while out_valid & !out_ready. No bubble collapse required beyond this.
//  - Config coherence: a write at edge N affects requests accepted at edge N+1 onward; requests already in
//    stage 1 keep their captured start/bank (table read only in stage 1).
//  - Simultaneous cfg_we and accept on same edge: the request sees the pre-write table.
//  - Reset mid-operation: in-flight results discarded, table cleared; no output pulse after reset.
// STRUCTURE
//  - Shared package jtcps1_gfx_pkg: gfx type one-hot constants (OBJ=0..STAR=4), entry field offsets,
//    ENTRYW/EB helpers.
//  - One sub-module: jtcps1_gfx_range_cmp (one entry: code_in, gfx_type, entry fields -> match); generated NENTRY times.
//  - Table, priority encoder, pipeline regs, and byte-write decode live in this module.
// TESTING
//  - Reset, no writes; lookup code 0x123 type SCR1 -> after 2 cycles miss=1, code_out=0x123, bank=0.
//  - Entry0 start=0x100 end=0x1FF tmask=SCR1 bank=2 en, bank_base[2]=0x040; code 0x123 SCR1 -> code_out=0x063, bank=2;
//    same code OBJ -> miss=1.
//  - Entries 1 and 3 both cover 0x200..0x2FF for OBJ, banks 1/3 -> code 0x250 OBJ returns bank=1 (lowest index wins).
//  - Boundaries: code==start and code==end match; start>end never matches; base 0x3F0 + offset 0x20 -> code_out=0x010 (wrap).
//  - Backpressure: stream 6 back-to-back requests, hold out_ready low 3 cycles mid-stream -> no loss, order kept,
//    outputs stable while stalled, in_ready low while out_valid&!out_ready.
//  - Rewrite entry0 bank on the same edge a request is accepted -> that request uses old bank, next uses new;
//    assert rst with two requests in flight -> out_valid=0 and all entries disabled afterwards.

Source files
------------

// File: rtl/jtcps1_gfx_pkg.sv
// Shared definitions for the CPS1 GFX bank mapper: gfx type one-hot codes,
// range-entry field offsets and entry/byte sizing helpers.
package jtcps1_gfx_pkg;

  localparam int unsigned GFX_TYPEW = 5;

  // gfx type one-hot codes (bit index OBJ=0 .. STAR=4)
  localparam logic [GFX_TYPEW-1:0] GFX_OBJ  = 5'b00001;
  localparam logic [GFX_TYPEW-1:0] GFX_SCR1 = 5'b00010;
  localparam logic [GFX_TYPEW-1:0] GFX_SCR2 = 5'b00100;
  localparam logic [GFX_TYPEW-1:0] GFX_SCR3 = 5'b01000;
  localparam logic [GFX_TYPEW-1:0] GFX_STAR = 5'b10000;

  // Entry layout, LSB first: start, end, tmask, bank, en
  localparam int unsigned OFF_START = 0;

  function automatic int unsigned off_stop(input int unsigned codew);
    return codew;
  endfunction

  function automatic int unsigned off_tmask(input int unsigned codew);
    return 2 * codew;
  endfunction

  function automatic int unsigned off_bank(input int unsigned codew, input int unsigned typew);
    return 2 * codew + typew;
  endfunction

  function automatic int unsigned off_en(input int unsigned codew, input int unsigned typew,
                                         input int unsigned bankw);
    return 2 * codew + typew + bankw;
  endfunction

  function automatic int unsigned entry_w(input int unsigned codew, input int unsigned typew,
                                          input int unsigned bankw);
    return off_en(codew, typew, bankw) + 1;
  endfunction

  function automatic int unsigned entry_bytes(input int unsigned entryw);
    return (entryw + 7) / 8;
  endfunction

  // A single bank still needs a 1-bit index port
  function automatic int unsigned bank_w(input int unsigned nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/jtcps1_gfx_range_cmp.sv
// Single range-entry matcher.
// Ports: code/gfx_type (request), start/stop/tmask/en (entry fields), match (combinational hit).
module jtcps1_gfx_range_cmp #(
  parameter int unsigned CODEW = 10,
  parameter int unsigned TYPEW = 5
) (
  input  logic [CODEW-1:0] code,
  input  logic [TYPEW-1:0] gfx_type,
  input  logic [CODEW-1:0] start,
  input  logic [CODEW-1:0] stop,
  input  logic [TYPEW-1:0] tmask,
  input  logic             en,
  output logic             match
);

  // start > stop can never satisfy both bounds, so it needs no special case
  assign match = en && (start <= code) && (code <= stop) && (|(tmask & gfx_type));

endmodule

// File: rtl/jtcps1_gfx_bank_lut.sv
// Pipelined, runtime-configurable GFX code-to-bank mapper.
// Ports: clk/rst; cfg_we/cfg_addr/cfg_din byte-wise table writes; bank_base per-bank base codes;
// in_valid/in_ready/gfx_type/code_in request; out_valid/out_ready/code_out/bank/miss result.
module jtcps1_gfx_bank_lut
  import jtcps1_gfx_pkg::*;
#(
  parameter  int unsigned NENTRY = 8,
  parameter  int unsigned CODEW  = 10,
  parameter  int unsigned TYPEW  = 5,
  parameter  int unsigned NBANK  = 4,
  localparam int unsigned BANKW  = bank_w(NBANK),
  localparam int unsigned ENTRYW = entry_w(CODEW, TYPEW, BANKW),
  localparam int unsigned EB     = entry_bytes(ENTRYW),
  localparam int unsigned AW     = (NENTRY * EB > 1) ? $clog2(NENTRY * EB) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [7:0]             cfg_din,
  input  logic [NBANK*CODEW-1:0] bank_base,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TYPEW-1:0]       gfx_type,
  input  logic [CODEW-1:0]       code_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CODEW-1:0]       code_out,
  output logic [BANKW-1:0]       bank,
  output logic                   miss
);

  localparam int unsigned NBYTE  = NENTRY * EB;
  localparam int unsigned O_STOP = off_stop(CODEW);
  localparam int unsigned O_TM   = off_tmask(CODEW);
  localparam int unsigned O_BANK = off_bank(CODEW, TYPEW);
  localparam int unsigned O_EN   = off_en(CODEW, TYPEW, BANKW);

  logic [ENTRYW-1:0] tbl [NENTRY];
  logic [NENTRY-1:0] hit;
  logic              any_hit;
  logic [CODEW-1:0]  win_start;
  logic [BANKW-1:0]  win_bank;
  logic              adv;

  int unsigned wr_addr, wr_entry, wr_lane;
  logic        wr_ok;

  logic             s1_valid;
  logic [CODEW-1:0] s1_code;
  logic [CODEW-1:0] s1_start;
  logic [BANKW-1:0] s1_bank;
  logic             s1_miss;
  logic [CODEW-1:0] rebased;

  // Byte-address decode; out-of-range writes are dropped
  always_comb begin
    wr_addr  = 32'(cfg_addr);
    wr_ok    = cfg_we && (wr_addr < NBYTE);
    wr_entry = wr_addr / EB;
    wr_lane  = wr_addr % EB;
  end

  // Range table; only the ENTRYW meaningful bits are stored, padding bits of the last byte are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < NENTRY; e++) tbl[e] <= '0;
    end else if (wr_ok) begin
      for (int unsigned e = 0; e < NENTRY; e++)
        for (int unsigned b = 0; b < ENTRYW; b++)
          if (e == wr_entry && (b / 8) == wr_lane) tbl[e][b] <= cfg_din[3'(b % 8)];
    end
  end

  // One comparator per entry
  for (genvar g = 0; g < NENTRY; g++) begin : g_cmp
    jtcps1_gfx_range_cmp #(
      .CODEW (CODEW),
      .TYPEW (TYPEW)
    ) u_cmp (
      .code     (code_in),
      .gfx_type (gfx_type),
      .start    (tbl[g][OFF_START +: CODEW]),
      .stop     (tbl[g][O_STOP +: CODEW]),
      .tmask    (tbl[g][O_TM +: TYPEW]),
      .en       (tbl[g][O_EN]),
      .match    (hit[g])
    );
  end

  // Priority encoder: scanning downward leaves the lowest matching index last
  always_comb begin
    win_start = '0;
    win_bank  = '0;
    any_hit   = |hit;
    for (int i = NENTRY - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_start = tbl[i][OFF_START +: CODEW];
        win_bank  = tbl[i][O_BANK +: BANKW];
      end
    end
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Rebase wraps modulo 2^CODEW by construction of the operand widths
  always_comb begin
    rebased = bank_base[32'(s1_bank) * CODEW +: CODEW] + (s1_code - s1_start);
  end

  // Two-stage pipeline, both stages advance together on adv
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_code   <= '0;
      s1_start  <= '0;
      s1_bank   <= '0;
      s1_miss   <= 1'b0;
      out_valid <= 1'b0;
      code_out  <= '0;
      bank      <= '0;
      miss      <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code  <= code_in;
        s1_start <= win_start;
        s1_bank  <= win_bank;
        s1_miss  <= !any_hit;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        code_out <= s1_miss ? s1_code : rebased;
        bank     <= s1_miss ? '0 : s1_bank;
        miss     <= s1_miss;
      end
    end
  end

endmodule

// File: tb/tb_jtcps1_gfx_bank_lut.sv
// Directed self-checking bench for jtcps1_gfx_bank_lut with default parameters
// (8 entries, 10-bit codes, 5 gfx types, 4 banks -> 28-bit entries, 4 bytes each).
module tb_jtcps1_gfx_bank_lut;

  localparam logic [4:0] T_OBJ  = 5'b00001;
  localparam logic [4:0] T_SCR1 = 5'b00010;
  localparam logic [4:0] T_SCR2 = 5'b00100;
  localparam logic [4:0] T_STAR = 5'b10000;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_din;
  logic [39:0] bank_base;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  gfx_type;
  logic [9:0]  code_in;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  code_out;
  logic [1:0]  bank;
  logic        miss;

  int n_checks = 0;
  int n_errors = 0;

  jtcps1_gfx_bank_lut dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_din   (cfg_din),
    .bank_base (bank_base),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gfx_type  (gfx_type),
    .code_in   (code_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code_out  (code_out),
    .bank      (bank),
    .miss      (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_entry(input logic [9:0] s, input logic [9:0] e,
                                           input logic [4:0] tm, input logic [1:0] b, input logic en);
    return {4'b0, en, b, tm, e, s};
  endfunction

  task automatic wr_entry(input int idx, input logic [9:0] s, input logic [9:0] e,
                          input logic [4:0] tm, input logic [1:0] b, input logic en);
    logic [31:0] w;
    w = mk_entry(s, e, tm, b, en);
    for (int lane = 0; lane < 4; lane++) begin
      cfg_we   = 1'b1;
      cfg_addr = 5'(idx * 4 + lane);
      cfg_din  = w[lane*8 +: 8];
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
  endtask

  // Single request with out_ready high; expects the result on the second edge after presentation
  task automatic lookup(input string tag, input logic [4:0] t, input logic [9:0] c,
                        input logic [9:0] ec, input logic [1:0] eb, input logic em);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    gfx_type  = t;
    code_in   = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"},  32'(n), 32'd2);
    check({tag, "_code"}, 32'(code_out), 32'(ec));
    check({tag, "_bank"}, 32'(bank), 32'(eb));
    check({tag, "_miss"}, 32'(miss), 32'(em));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sent, rcv;
    logic stalled_prev;
    logic [9:0] held_code;
    logic [1:0] held_bank;
    logic [31:0] w;

    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_din   = '0;
    in_valid  = 1'b0;
    gfx_type  = '0;
    code_in   = '0;
    out_ready = 1'b1;
    // bases: bank3=0x300 bank2=0x040 bank1=0x080 bank0=0x3F0
    bank_base = {10'h300, 10'h040, 10'h080, 10'h3F0};
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_code",  32'(code_out),  32'd0);
    check("rst_bank",  32'(bank),      32'd0);
    check("rst_miss",  32'(miss),      32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);

    // Empty table: everything misses, code passes through
    lookup("empty", T_SCR1, 10'h123, 10'h123, 2'd0, 1'b1);

    // Entry0 0x100..0x1FF SCR1 -> bank2 (base 0x040)
    wr_entry(0, 10'h100, 10'h1FF, T_SCR1, 2'd2, 1'b1);
    lookup("e0_hit",   T_SCR1, 10'h123, 10'h063, 2'd2, 1'b0);
    lookup("e0_wrong_type", T_OBJ, 10'h123, 10'h123, 2'd0, 1'b1);

    // Overlapping entries 1 and 3: lowest index wins
    wr_entry(1, 10'h200, 10'h2FF, T_OBJ, 2'd1, 1'b1);
    wr_entry(3, 10'h200, 10'h2FF, T_OBJ, 2'd3, 1'b1);
    lookup("prio_low", T_OBJ, 10'h250, 10'h0D0, 2'd1, 1'b0);
    wr_entry(1, 10'h200, 10'h2FF, T_OBJ, 2'd1, 1'b0);
    lookup("prio_e3",  T_OBJ, 10'h250, 10'h350, 2'd3, 1'b0);

    // Inclusive bounds
    lookup("at_start", T_SCR1, 10'h100, 10'h040, 2'd2, 1'b0);
    lookup("at_end",   T_SCR1, 10'h1FF, 10'h13F, 2'd2, 1'b0);
    lookup("past_end", T_SCR1, 10'h200, 10'h200, 2'd0, 1'b1);

    // Inverted range never matches
    wr_entry(2, 10'h300, 10'h2FF, T_SCR2, 2'd1, 1'b1);
    lookup("inv_lo", T_SCR2, 10'h300, 10'h300, 2'd0, 1'b1);
    lookup("inv_hi", T_SCR2, 10'h2FF, 10'h2FF, 2'd0, 1'b1);

    // Wrap: base 0x3F0 + offset 0x20 -> 0x010
    wr_entry(4, 10'h380, 10'h3FF, T_STAR, 2'd0, 1'b1);
    lookup("wrap", T_STAR, 10'h3A0, 10'h010, 2'd0, 1'b0);

    // Back-to-back stream with a 3-cycle consumer stall
    sent = 0;
    rcv = 0;
    stalled_prev = 1'b0;
    held_code = '0;
    held_bank = '0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 6);
      gfx_type  = T_SCR1;
      code_in   = 10'h100 + 10'(sent);
      #1;
      if (out_valid && !out_ready) check("bp_in_ready", 32'(in_ready), 32'd0);
      if (stalled_prev) begin
        check("bp_hold_code", 32'(code_out), 32'(held_code));
        check("bp_hold_bank", 32'(bank), 32'(held_bank));
      end
      if (out_valid && out_ready) begin
        check("bp_code", 32'(code_out), 32'(10'h040 + 10'(rcv)));
        check("bp_bank", 32'(bank), 32'd2);
        rcv++;
      end
      stalled_prev = out_valid && !out_ready;
      held_code = code_out;
      held_bank = bank;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 32'(rcv), 32'd6);
    @(posedge clk); #1;

    // Rewrite entry0 bank (byte 3) on the same edge a request is accepted
    w = mk_entry(10'h100, 10'h1FF, T_SCR1, 2'd1, 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    gfx_type  = T_SCR1;
    code_in   = 10'h123;
    cfg_we    = 1'b1;
    cfg_addr  = 5'd3;
    cfg_din   = w[31:24];
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("coh_old_valid", 32'(out_valid), 32'd1);
    check("coh_old_bank",  32'(bank), 32'd2);
    check("coh_old_code",  32'(code_out), 32'h063);
    @(posedge clk); #1;
    check("coh_new_valid", 32'(out_valid), 32'd1);
    check("coh_new_bank",  32'(bank), 32'd1);
    check("coh_new_code",  32'(code_out), 32'h0A3);
    @(posedge clk); #1;

    // Reset with two requests in flight
    in_valid = 1'b1;
    code_in  = 10'h150;
    @(posedge clk); #1;
    code_in  = 10'h160;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("in_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    lookup("clr_e0", T_SCR1, 10'h123, 10'h123, 2'd0, 1'b1);
    lookup("clr_e3", T_OBJ,  10'h250, 10'h250, 2'd0, 1'b1);
    lookup("clr_e4", T_STAR, 10'h3A0, 10'h3A0, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
